// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory access arbiter.
package mem_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WR_DONE = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the requester that did not
// win last time gets the grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_id,
  output logic       gnt_valid
);

  // Winner selection
  always_comb begin
    gnt_id    = GNT_A;
    gnt_valid = req[0] | req[1];
    if (req[0] && req[1]) begin
      gnt_id = ~last_gnt;
    end else if (req[1]) begin
      gnt_id = GNT_B;
    end else begin
      gnt_id = GNT_A;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-port memory controller between requesters A and B with
// round-robin arbitration and a single outstanding transaction.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  output logic              A_ACK,
  output logic [DATA_W-1:0] A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              B_ACK,
  output logic [DATA_W-1:0] B_RDATA,
  output logic [DATA_W-1:0] MEM_DATA_IN,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic              MEMR,
  output logic              MEMW,
  input  logic [DATA_W-1:0] MEM_DATA_OUT
);

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              memr_q, memr_d;
  logic              memw_q, memw_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic              gnt_id;
  logic              gnt_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req       ({B_REQ, A_REQ}),
    .last_gnt  (last_gnt_q),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  assign sel_we    = (gnt_id == GNT_B) ? B_WE    : A_WE;
  assign sel_addr  = (gnt_id == GNT_B) ? B_ADDR  : A_ADDR;
  assign sel_wdata = (gnt_id == GNT_B) ? B_WDATA : A_WDATA;

  // Next-state and output computation for the transaction FSM
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    memr_d     = 1'b0;
    memw_d     = 1'b0;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The ACK cycle of a read lands in IDLE; granting is held off for it
        // so a still-high REQ is taken as a new request one cycle later.
        if (gnt_valid && !(a_ack_q || b_ack_q)) begin
          win_d      = gnt_id;
          last_gnt_d = gnt_id;
          we_d       = sel_we;
          addr_d     = sel_addr;
          din_d      = sel_wdata;
          memr_d     = ~sel_we;
          memw_d     = sel_we;
          state_d    = ST_ISSUE;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_WR_DONE;
          if (win_q == GNT_B) begin
            b_ack_d = 1'b1;
          end else begin
            a_ack_d = 1'b1;
          end
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_DONE: begin
        state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        state_d = ST_IDLE;
        if (win_q == GNT_B) begin
          b_rdata_d = MEM_DATA_OUT;
          b_ack_d   = 1'b1;
        end else begin
          a_rdata_d = MEM_DATA_OUT;
          a_ack_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= GNT_B;
      win_q      <= GNT_A;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      memr_q     <= 1'b0;
      memw_q     <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      memr_q     <= memr_d;
      memw_q     <= memw_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
    end
  end

  assign A_ACK       = a_ack_q;
  assign B_ACK       = b_ack_q;
  assign A_RDATA     = a_rdata_q;
  assign B_RDATA     = b_rdata_q;
  assign MEM_DATA_IN = din_q;
  assign MEM_ADDRESS = addr_q;
  assign MEMR        = memr_q;
  assign MEMW        = memw_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural 16x16 memory
// controller model (registered read data, one cycle after MEMR).
module tb_mem_access_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        A_REQ, A_WE, B_REQ, B_WE;
  logic [3:0]  A_ADDR, B_ADDR;
  logic [15:0] A_WDATA, B_WDATA;
  logic        A_ACK, B_ACK, MEMR, MEMW;
  logic [15:0] A_RDATA, B_RDATA, MEM_DATA_IN;
  logic [3:0]  MEM_ADDRESS;
  logic [15:0] MEM_DATA_OUT = 16'h0000;
  logic [15:0] mem [16] = '{default: 16'h0000};

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_access_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_ACK(A_ACK), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_ACK(B_ACK), .B_RDATA(B_RDATA),
    .MEM_DATA_IN(MEM_DATA_IN), .MEM_ADDRESS(MEM_ADDRESS),
    .MEMR(MEMR), .MEMW(MEMW), .MEM_DATA_OUT(MEM_DATA_OUT)
  );

  // memory controller model
  always @(posedge CLK) begin
    if (MEMW) mem[MEM_ADDRESS] <= MEM_DATA_IN;
    if (MEMR) MEM_DATA_OUT <= mem[MEM_ADDRESS];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // invariants: no MEMR/MEMW overlap, no ACK overlap
  always @(negedge CLK) begin
    if (!RST) check("invariant_overlap", {62'd0, MEMR & MEMW, A_ACK & B_ACK}, 64'd0);
  end

  function automatic logic [55:0] outs();
    return {MEMR, MEMW, A_ACK, B_ACK, MEM_ADDRESS, MEM_DATA_IN, A_RDATA, B_RDATA};
  endfunction

  typedef struct packed {
    logic        a_req;
    logic        a_we;
    logic [3:0]  a_addr;
    logic [15:0] a_wdata;
    logic        b_req;
    logic        b_we;
    logic [3:0]  b_addr;
    logic [15:0] b_wdata;
    logic [3:0]  e_ctl;   // {MEMR, MEMW, A_ACK, B_ACK}
    logic [3:0]  e_addr;
    logic [15:0] e_din;
    logic [15:0] e_ard;
    logic [15:0] e_brd;
  } vec_t;

  vec_t vecs [7];

  logic        ack_who  [8];
  logic [15:0] ack_data [8];
  int          ack_cyc  [8];
  int          n_acks;

  task automatic clear_inputs();
    A_REQ = 1'b0; A_WE = 1'b0; A_ADDR = 4'd0; A_WDATA = 16'h0000;
    B_REQ = 1'b0; B_WE = 1'b0; B_ADDR = 4'd0; B_WDATA = 16'h0000;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", {8'd0, outs()}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Tick until n ACKs are seen; a requester without keep drops REQ in its ACK cycle.
  task automatic run_acks(input int n, input bit keep_a, input bit keep_b, input int budget);
    n_acks = 0;
    for (int c = 0; c < budget && n_acks < n; c++) begin
      @(posedge CLK);
      #1;
      if (A_ACK || B_ACK) begin
        ack_who[n_acks]  = B_ACK;
        ack_data[n_acks] = B_ACK ? B_RDATA : A_RDATA;
        ack_cyc[n_acks]  = c;
        n_acks++;
        if (A_ACK && !keep_a) A_REQ = 1'b0;
        if (B_ACK && !keep_b) B_REQ = 1'b0;
      end
    end
    check("ack_count", 64'(n_acks), 64'(n));
  endtask

  task automatic wait_strobe(input bit want_memr, input int budget);
    int c;
    c = 0;
    do begin
      @(posedge CLK);
      #1;
      c++;
    end while (!(want_memr ? MEMR : MEMW) && c < budget);
    check("strobe_seen", {63'd0, (want_memr ? MEMR : MEMW)}, 64'd1);
  endtask

  initial begin
    clear_inputs();

    // tests 1 and 2: A write addr 3, then B read addr 3, cycle by cycle
    vecs[0] = '{a_req:1'b1, a_we:1'b1, a_addr:4'd3, a_wdata:16'hBEEF, b_req:1'b0, b_we:1'b0, b_addr:4'd0, b_wdata:16'h0000,
                e_ctl:4'b0100, e_addr:4'd3, e_din:16'hBEEF, e_ard:16'h0000, e_brd:16'h0000};
    vecs[1] = '{a_req:1'b1, a_we:1'b1, a_addr:4'd3, a_wdata:16'hBEEF, b_req:1'b0, b_we:1'b0, b_addr:4'd0, b_wdata:16'h0000,
                e_ctl:4'b0010, e_addr:4'd3, e_din:16'hBEEF, e_ard:16'h0000, e_brd:16'h0000};
    vecs[2] = '{a_req:1'b0, a_we:1'b1, a_addr:4'd3, a_wdata:16'hBEEF, b_req:1'b0, b_we:1'b0, b_addr:4'd0, b_wdata:16'h0000,
                e_ctl:4'b0000, e_addr:4'd3, e_din:16'hBEEF, e_ard:16'h0000, e_brd:16'h0000};
    vecs[3] = '{a_req:1'b0, a_we:1'b0, a_addr:4'd0, a_wdata:16'h0000, b_req:1'b1, b_we:1'b0, b_addr:4'd3, b_wdata:16'h0000,
                e_ctl:4'b1000, e_addr:4'd3, e_din:16'h0000, e_ard:16'h0000, e_brd:16'h0000};
    vecs[4] = '{a_req:1'b0, a_we:1'b0, a_addr:4'd0, a_wdata:16'h0000, b_req:1'b1, b_we:1'b0, b_addr:4'd3, b_wdata:16'h0000,
                e_ctl:4'b0000, e_addr:4'd3, e_din:16'h0000, e_ard:16'h0000, e_brd:16'h0000};
    vecs[5] = '{a_req:1'b0, a_we:1'b0, a_addr:4'd0, a_wdata:16'h0000, b_req:1'b1, b_we:1'b0, b_addr:4'd3, b_wdata:16'h0000,
                e_ctl:4'b0001, e_addr:4'd3, e_din:16'h0000, e_ard:16'h0000, e_brd:16'hBEEF};
    vecs[6] = '{a_req:1'b0, a_we:1'b0, a_addr:4'd0, a_wdata:16'h0000, b_req:1'b0, b_we:1'b0, b_addr:4'd3, b_wdata:16'h0000,
                e_ctl:4'b0000, e_addr:4'd3, e_din:16'h0000, e_ard:16'h0000, e_brd:16'hBEEF};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      A_REQ = vecs[i].a_req; A_WE = vecs[i].a_we; A_ADDR = vecs[i].a_addr; A_WDATA = vecs[i].a_wdata;
      B_REQ = vecs[i].b_req; B_WE = vecs[i].b_we; B_ADDR = vecs[i].b_addr; B_WDATA = vecs[i].b_wdata;
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d", i), {8'd0, outs()},
            {8'd0, vecs[i].e_ctl, vecs[i].e_addr, vecs[i].e_din, vecs[i].e_ard, vecs[i].e_brd});
    end

    // test 3: simultaneous held writes from reset -> A, B, A, B, 3 cycles apart
    do_reset();
    A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 4'd1; A_WDATA = 16'h1111;
    B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 4'd2; B_WDATA = 16'h2222;
    run_acks(4, 1'b1, 1'b1, 40);
    A_REQ = 1'b0; B_REQ = 1'b0;
    check("rr_order", {60'd0, ack_who[0], ack_who[1], ack_who[2], ack_who[3]}, {60'd0, 4'b0101});
    check("rr_ack_cycles", {ack_cyc[0][15:0], ack_cyc[1][15:0], ack_cyc[2][15:0], ack_cyc[3][15:0]},
          {16'd1, 16'd4, 16'd7, 16'd10});
    check("rr_mem_contents", {32'd0, mem[1], mem[2]}, {32'd0, 16'h1111, 16'h2222});

    // test 4: init addr 5, then A read vs held B write to addr 5
    B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 4'd5; B_WDATA = 16'h0000;
    run_acks(1, 1'b0, 1'b0, 20);
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 4'd5; A_WDATA = 16'h0000;
    B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 4'd5; B_WDATA = 16'h1234;
    run_acks(3, 1'b1, 1'b0, 40);
    A_REQ = 1'b0; B_REQ = 1'b0;
    check("rw_order", {61'd0, ack_who[0], ack_who[1], ack_who[2]}, {61'd0, 3'b010});
    check("rw_old_value", {48'd0, ack_data[0]}, {48'd0, 16'h0000});
    check("rw_new_value", {48'd0, ack_data[2]}, {48'd0, 16'h1234});
    check("read_ack_spacing", 64'(ack_cyc[2] - ack_cyc[1]), 64'd4);

    // test 5: REQ dropped and address changed during ISSUE of a write
    A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 4'd7; A_WDATA = 16'hCAFE;
    wait_strobe(1'b0, 10);
    check("issue_addr", {60'd0, MEM_ADDRESS}, {60'd0, 4'd7});
    A_REQ = 1'b0; A_ADDR = 4'd8; A_WDATA = 16'h0BAD;
    @(posedge CLK);
    #1;
    check("drop_ack", {62'd0, A_ACK, B_ACK}, {62'd0, 2'b10});
    @(posedge CLK);
    #1;
    check("drop_mem", {32'd0, mem[7], mem[8]}, {32'd0, 16'hCAFE, 16'h0000});
    check("drop_ack_clear", {62'd0, A_ACK, B_ACK}, 64'd0);

    // test 6: reset during RD_WAIT, then a fresh B read
    B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 4'd7; B_WDATA = 16'h0000;
    wait_strobe(1'b1, 10);
    @(posedge CLK);
    #1;
    check("rd_wait_no_ack", {62'd0, A_ACK, B_ACK}, 64'd0);
    #2;
    RST = 1'b1;
    #1;
    check("async_reset_outs", {8'd0, outs()}, 64'd0);
    B_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hold_outs", {8'd0, outs()}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    B_REQ = 1'b1;
    run_acks(1, 1'b0, 1'b0, 20);
    check("post_reset_read", {47'd0, ack_who[0], ack_data[0]}, {47'd0, 1'b1, 16'hCAFE});
    check("post_reset_latency", 64'(ack_cyc[0]), 64'd2);
    repeat (2) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
